config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Upstream configuration stage for the fpga fabric. Takes a serial bitstream, finds a sync word and shifts the payload into a shadow register.
- Checks the payload with a CRC-8, then commits it atomically to the parallel configuration vector. That vector drives the logic-tile LUT/flip-flop-select bits and the switch-box configure bits.
- The fabric never sees a partially loaded or corrupt configuration.

Parameters:
- CFG_BITS, 1113, payload length in bits (25 tiles x 33 + 18 switch boxes x 16).
- SYNC_W, 16, sync word width.
- SYNC_WORD, 16'hA5C3, pattern that starts a frame.

Ports:
- clock, input, 1, single system clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high.
- cfg_in, input, 1, serial data bit.
- cfg_en, input, 1, cfg_in is sampled on a clock edge only when this is high.
- abort, input, 1, synchronous frame abort.
- cfg_data, output, CFG_BITS, committed configuration vector.
- cfg_done, output, 1, last frame passed CRC and was committed (level).
- cfg_error, output, 1, last frame failed CRC (level).
- busy, output, 1, high in LOAD, CRC and CHECK.
- bit_count, output, 11 (>= clog2(CFG_BITS+1)), payload bits received in the current frame.

Behaviour:
- Reset: state=HUNT; cfg_data=0, cfg_done=0, cfg_error=0, busy=0, bit_count=0; shadow, sync window, crc and rx_crc all cleared.
- Bit accepted: rising edge with cfg_en=1 and abort=0. With cfg_en=0, all state holds.
- HUNT:
  - Each accepted bit shifts into the window: win <= {win[SYNC_W-2:0], cfg_in}.
  - If the next window value equals SYNC_WORD: enter LOAD next cycle; clear cfg_done, cfg_error, bit_count and crc.
  - Sync detection overlaps arbitrary bit alignment.
- LOAD:
  - Each accepted bit: shadow <= {shadow[CFG_BITS-2:0], cfg_in}. The first payload bit ends up in cfg_data[CFG_BITS-1].
  - Per accepted bit, CRC-8 update: poly 0x07, init 0x00, MSB-first. fb = crc[7]^cfg_in; crc <= {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
  - bit_count increments per accepted bit.
  - On the accepted bit that makes bit_count==CFG_BITS, go to CRC.
- CRC:
  - 8 accepted bits shift MSB-first into rx_crc; crc is not updated.
  - After the 8th bit, go to CHECK.
- CHECK (one cycle, cfg_en ignored, any bit presented is dropped):
  - rx_crc==crc: cfg_data <= shadow and cfg_done <= 1.
  - Otherwise: cfg_error <= 1 and cfg_data is unchanged.
  - In both cases, next state is HUNT with the window cleared to 0.
- Latency: cfg_done/cfg_error and the new cfg_data are visible 2 edges after the edge that accepts the last CRC bit (CRC->CHECK, then CHECK->HUNT).
- Status flags hold until the next sync detection, abort or reset.
- abort:
  - Any state goes to HUNT next cycle; window, shadow, crc and bit_count are cleared; cfg_done and cfg_error are cleared.
  - cfg_data is retained.
  - abort with cfg_en in the same cycle: abort wins and the bit is discarded.
- Reset mid-frame: full reset values as above, including cfg_data=0.
- busy = (state==LOAD || state==CRC || state==CHECK).
- Sync pattern inside the payload is not special; it is treated as data.
- bit_count saturates at CFG_BITS; in the CRC state it holds CFG_BITS.

Decomposition:
- Shared package holds:
  - the state enum (HUNT, LOAD, CRC, CHECK);
  - CRC8_POLY=8'h07;
  - the default SYNC_WORD;
  - the per-tile and per-switch-box bit widths (33, 16);
  - the tile and switch-box counts used to derive CFG_BITS.
- Sub-module: crc8_serial (clock, reset, clear, en, din, crc[7:0]), instantiated once.

Test Plan:
- Bench uses CFG_BITS=16, SYNC_WORD=16'hA5C3.
- Good frame: send 16'hA5C3, then payload 16'h8001, then the correct CRC. Required:
  - busy high for the 16+8 payload/CRC bits plus the CHECK cycle;
  - cfg_data==16'h8001, cfg_done=1 and cfg_error=0 two edges after the last CRC bit.
- Bad CRC: same frame with CRC bit 0 inverted. Required: cfg_error=1, cfg_done=0, cfg_data keeps its previous value.
- Misaligned sync plus gaps: send 3 junk bits 1,0,1 before the sync word, and deassert cfg_en on random cycles throughout. Required: the frame loads exactly as in the good-frame case and bit_count tracks only accepted bits.
- Abort mid-LOAD at bit_count==7, with cfg_en=1 in the same cycle. Required:
  - state returns to HUNT, bit_count=0, busy=0, cfg_data unchanged;
  - a following good frame with payload 16'h1234 commits 16'h1234.
- Reset mid-frame after the sync word and 5 payload bits. Required: all outputs 0 on the next edge; a sync word sent after reset is detected normally.
- Back-to-back frames: good frame (16'hFFFF), then a bad-CRC frame immediately after. Required: cfg_done clears at the second sync detection, cfg_error sets, cfg_data stays 16'hFFFF.

Source files
------------

// File: rtl/config_loader_pkg.sv
// Shared types and constants for the serial configuration loader.
package config_loader_pkg;

   typedef enum logic [1:0] {
      StHunt,
      StLoad,
      StCrc,
      StCheck
   } state_e;

   localparam logic [7:0]  CRC8_POLY     = 8'h07;
   localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;

   // Fabric geometry that sets the payload length.
   localparam int unsigned TILE_BITS    = 33;
   localparam int unsigned SB_BITS      = 16;
   localparam int unsigned TILE_CNT     = 25;
   localparam int unsigned SB_CNT       = 18;
   localparam int unsigned CFG_BITS_DEF = TILE_CNT * TILE_BITS + SB_CNT * SB_BITS;

   // Width of the payload bit counter.
   localparam int unsigned CNT_W = 11;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB first, init 0) with synchronous clear.
module crc8_serial
   import config_loader_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   input  logic       din,
   output logic [7:0] crc
);

   logic [7:0] crc_q, crc_d;
   logic       fb;

   // Next CRC value: clear has priority over a data update.
   always_comb begin
      fb    = crc_q[7] ^ din;
      crc_d = crc_q;
      if (clear) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
      end
   end

   // CRC register.
   always_ff @(posedge clock) begin
      if (reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: hunts for a sync word, shifts the payload into a
// shadow register, checks CRC-8 and commits the payload atomically.
module config_loader
   import config_loader_pkg::*;
#(
   parameter int unsigned       CFG_BITS  = CFG_BITS_DEF,
   parameter int unsigned       SYNC_W    = 16,
   parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_in,
   input  logic                cfg_en,
   input  logic                abort,
   output logic [CFG_BITS-1:0] cfg_data,
   output logic                cfg_done,
   output logic                cfg_error,
   output logic                busy,
   output logic [CNT_W-1:0]    bit_count
);

   localparam logic [CNT_W-1:0] CntMax  = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(CFG_BITS - 1);

   state_e              state_q, state_d;
   logic [SYNC_W-1:0]   win_q, win_d, win_next;
   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] data_q, data_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          rx_q, rx_d;
   logic [2:0]          rxn_q, rxn_d;
   logic                crc_clr, crc_en;
   logic [7:0]          crc_val;

   crc8_serial u_crc (
      .clock (clock),
      .reset (reset),
      .clear (crc_clr),
      .en    (crc_en),
      .din   (cfg_in),
      .crc   (crc_val)
   );

   // Next-state logic; abort overrides everything, including a bit offered in the same cycle.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      done_d   = done_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      rx_d     = rx_q;
      rxn_d    = rxn_q;
      crc_clr  = 1'b0;
      crc_en   = 1'b0;
      win_next = {win_q[SYNC_W-2:0], cfg_in};

      if (abort) begin
         state_d  = StHunt;
         win_d    = '0;
         shadow_d = '0;
         cnt_d    = '0;
         done_d   = 1'b0;
         err_d    = 1'b0;
         rxn_d    = '0;
         crc_clr  = 1'b1;
      end else begin
         unique case (state_q)
            StHunt: begin
               if (cfg_en) begin
                  win_d = win_next;
                  if (win_next == SYNC_WORD) begin
                     state_d = StLoad;
                     done_d  = 1'b0;
                     err_d   = 1'b0;
                     cnt_d   = '0;
                     crc_clr = 1'b1;
                  end
               end
            end
            StLoad: begin
               if (cfg_en) begin
                  shadow_d = {shadow_q[CFG_BITS-2:0], cfg_in};
                  crc_en   = 1'b1;
                  if (cnt_q != CntMax) begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (cnt_q == CntLast) begin
                     state_d = StCrc;
                     rxn_d   = '0;
                  end
               end
            end
            StCrc: begin
               if (cfg_en) begin
                  rx_d  = {rx_q[6:0], cfg_in};
                  rxn_d = rxn_q + 1'b1;
                  if (rxn_q == 3'd7) begin
                     state_d = StCheck;
                  end
               end
            end
            StCheck: begin
               // Input is ignored here; the verdict is taken in a cycle of its own.
               if (rx_q == crc_val) begin
                  data_d = shadow_q;
                  done_d = 1'b1;
                  err_d  = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
               state_d = StHunt;
               win_d   = '0;
            end
            default: state_d = StHunt;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StHunt;
         win_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         rx_q     <= '0;
         rxn_q    <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         rx_q     <= rx_d;
         rxn_q    <= rxn_d;
      end
   end

   assign cfg_data  = data_q;
   assign cfg_done  = done_q;
   assign cfg_error = err_q;
   assign bit_count = cnt_q;
   assign busy      = (state_q != StHunt);

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: a frame-level model is compared with the
// DUT on every cycle, and key points of each scenario are pinned with literals.
module tb_config_loader;

   localparam int unsigned CB   = 16;
   localparam logic [15:0] SYNC = 16'hA5C3;

   logic          clock  = 1'b0;
   logic          reset  = 1'b1;
   logic          cfg_in = 1'b0;
   logic          cfg_en = 1'b0;
   logic          abort  = 1'b0;
   logic [CB-1:0] cfg_data;
   logic          cfg_done, cfg_error, busy;
   logic [10:0]   bit_count;

   config_loader #(
      .CFG_BITS  (CB),
      .SYNC_W    (16),
      .SYNC_WORD (SYNC)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_in    (cfg_in),
      .cfg_en    (cfg_en),
      .abort     (abort),
      .cfg_data  (cfg_data),
      .cfg_done  (cfg_done),
      .cfg_error (cfg_error),
      .busy      (busy),
      .bit_count (bit_count)
   );

   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_on  = 1'b0;
   bit gaps    = 1'b0;

   // Frame-level model: phase, sync window, payload bits as a queue, received CRC.
   typedef enum int {MHunt, MLoad, MCrc, MCheck} mphase_e;
   mphase_e       m_phase;
   logic [15:0]   m_win;
   bit            pay_q[$];
   logic [7:0]    m_rx;
   int            m_rxn;
   logic [CB-1:0] m_data;
   bit            m_done, m_err;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference CRC-8 (poly 0x07, init 0), computed a byte at a time.
   function automatic logic [7:0] crc8(input logic [15:0] v);
      logic [7:0] c;
      c = 8'h00;
      for (int k = 1; k >= 0; k--) begin
         c = c ^ v[k*8 +: 8];
         for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic [CB-1:0] pay_vec();
      logic [CB-1:0] v;
      v = '0;
      foreach (pay_q[i]) v = {v[CB-2:0], pay_q[i]};
      return v;
   endfunction

   task automatic model_update(input bit r, input bit en, input bit b, input bit ab);
      if (r) begin
         m_phase = MHunt; m_win = '0; pay_q.delete(); m_rx = '0; m_rxn = 0;
         m_data = '0; m_done = 1'b0; m_err = 1'b0;
      end else if (ab) begin
         m_phase = MHunt; m_win = '0; pay_q.delete(); m_done = 1'b0; m_err = 1'b0;
      end else if (m_phase == MCheck) begin
         if (crc8(pay_vec()) == m_rx) begin
            m_data = pay_vec(); m_done = 1'b1; m_err = 1'b0;
         end else begin
            m_err = 1'b1;
         end
         m_phase = MHunt; m_win = '0;
      end else if (en) begin
         case (m_phase)
            MHunt: begin
               m_win = {m_win[14:0], b};
               if (m_win == SYNC) begin
                  m_phase = MLoad; pay_q.delete(); m_done = 1'b0; m_err = 1'b0;
               end
            end
            MLoad: begin
               pay_q.push_back(b);
               if (pay_q.size() == CB) begin m_phase = MCrc; m_rxn = 0; end
            end
            MCrc: begin
               m_rx = {m_rx[6:0], b};
               m_rxn++;
               if (m_rxn == 8) m_phase = MCheck;
            end
            default: ;
         endcase
      end
   endtask

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clock) begin
      if (chk_on) begin
         check("cfg_data", 32'(cfg_data), 32'(m_data));
         check("cfg_done", 32'(cfg_done), 32'(m_done));
         check("cfg_error", 32'(cfg_error), 32'(m_err));
         check("busy", 32'(busy), 32'(m_phase != MHunt));
         check("bit_count", 32'(bit_count), 32'(pay_q.size()));
      end
   end

   task automatic step(input bit en, input bit b, input bit ab, input bit r);
      reset = r; cfg_en = en; cfg_in = b; abort = ab;
      @(posedge clock);
      #1;
      model_update(r, en, b, ab);
      chk_on = 1'b1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_bit(input bit b);
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      step(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic send16(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send8(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   // Payload, CRC (optionally corrupted) and the verdict cycle; sync sent by the caller.
   task automatic send_body(input logic [15:0] pay, input logic [7:0] flip);
      send16(pay);
      check("count_full", 32'(bit_count), 32'd16);
      send8(crc8(pay) ^ flip);
      check("busy_last_crc", 32'(busy), 32'd1);
      idle();
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_data", 32'(cfg_data), 32'h0);
      check("rst_done", 32'(cfg_done), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_count", 32'(bit_count), 32'h0);

      check("crc_8001", 32'(crc8(16'h8001)), 32'hB1);
      check("crc_ffff", 32'(crc8(16'hFFFF)), 32'h24);
      check("crc_1234", 32'(crc8(16'h1234)), 32'hF1);

      // Good frame.
      idle();
      send16(SYNC);
      check("sync_busy", 32'(busy), 32'd1);
      send_body(16'h8001, 8'h00);
      check("good_data", 32'(cfg_data), 32'h8001);
      check("good_done", 32'(cfg_done), 32'd1);
      check("good_err", 32'(cfg_error), 32'd0);
      check("good_busy", 32'(busy), 32'd0);

      // Bad CRC.
      send16(SYNC);
      send_body(16'h8001, 8'h01);
      check("bad_err", 32'(cfg_error), 32'd1);
      check("bad_done", 32'(cfg_done), 32'd0);
      check("bad_data", 32'(cfg_data), 32'h8001);

      // Misaligned sync with random cfg_en gaps.
      gaps = 1'b1;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send16(SYNC);
      send16(16'h8000);
      check("gap_count", 32'(bit_count), 32'd16);
      send8(crc8(16'h8000));
      idle();
      gaps = 1'b0;
      check("gap_data", 32'(cfg_data), 32'h8000);
      check("gap_done", 32'(cfg_done), 32'd1);
      check("gap_err", 32'(cfg_error), 32'd0);

      // Abort at bit_count==7 with a bit offered in the same cycle.
      send16(SYNC);
      for (int i = 15; i >= 9; i--) send_bit(1'(16'h1234 >> i));
      check("pre_abort_count", 32'(bit_count), 32'd7);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("abort_count", 32'(bit_count), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_data", 32'(cfg_data), 32'h8000);
      check("abort_done", 32'(cfg_done), 32'd0);
      send16(SYNC);
      send_body(16'h1234, 8'h00);
      check("post_abort_data", 32'(cfg_data), 32'h1234);
      check("post_abort_done", 32'(cfg_done), 32'd1);

      // Reset mid-frame.
      send16(SYNC);
      for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("mid_rst_data", 32'(cfg_data), 32'h0);
      check("mid_rst_done", 32'(cfg_done), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_count", 32'(bit_count), 32'd0);
      send16(SYNC);
      check("resync_busy", 32'(busy), 32'd1);

      // Back-to-back: good 16'hFFFF, then a bad-CRC frame.
      send_body(16'hFFFF, 8'h00);
      check("b2b_good_data", 32'(cfg_data), 32'hFFFF);
      check("b2b_good_done", 32'(cfg_done), 32'd1);
      send16(SYNC);
      check("b2b_sync_done", 32'(cfg_done), 32'd0);
      send_body(16'hFFFF, 8'h01);
      check("b2b_err", 32'(cfg_error), 32'd1);
      check("b2b_done", 32'(cfg_done), 32'd0);
      check("b2b_data", 32'(cfg_data), 32'hFFFF);

      idle();
      idle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
